tri_scan: RTL

Triangle scan-converter. It is the query generator that sits upstream of the point-in-triangle test path. It accepts three signed 12-bit vertices and walks their bounding box one candidate pixel per cycle in raster order. It evaluates the three edge functions for each candidate and streams the coordinates of covered pixels out on a valid/ready interface. It reports completion and a covered-pixel count for the triangle.

---
 rtl/tri_scan.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tri_scan.sv
// Triangle scan-converter: walks the bounding box of three signed 12-bit vertices
// in raster order and streams covered pixel coordinates over valid/ready.
module tri_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] v0x,
  input  logic [11:0] v0y,
  input  logic [11:0] v1x,
  input  logic [11:0] v1y,
  input  logic [11:0] v2x,
  input  logic [11:0] v2y,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_x,
  output logic [11:0] out_y,
  output logic        done,
  output logic [23:0] pix_count
);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  // Eab(P) = (bx-ax)*(Py-ay) - (by-ay)*(Px-ax), computed at full precision.
  function automatic logic signed [26:0] edge_fn(
    input logic signed [11:0] sx, sy, tx, ty, px, py);
    logic signed [12:0] dxe, dye, dxp, dyp;
    logic signed [25:0] m0, m1;
    dxe = 13'(tx) - 13'(sx);
    dye = 13'(ty) - 13'(sy);
    dxp = 13'(px) - 13'(sx);
    dyp = 13'(py) - 13'(sy);
    m0  = 26'(dxe) * 26'(dyp);
    m1  = 26'(dye) * 26'(dxp);
    return 27'(m0) - 27'(m1);
  endfunction

  function automatic logic signed [11:0] min3(input logic signed [11:0] a, b, c);
    logic signed [11:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [11:0] max3(input logic signed [11:0] a, b, c);
    logic signed [11:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic inside3(input logic signed [26:0] a, b, c);
    logic nonneg, nonpos;
    nonneg = !a[26] && !b[26] && !c[26];
    nonpos = (a[26] || (a == '0)) && (b[26] || (b == '0)) && (c[26] || (c == '0));
    return nonneg || nonpos;
  endfunction

  state_t             state;
  logic signed [11:0] r0x, r0y, r1x, r1y, r2x, r2y;
  logic signed [11:0] xmin, xmax, ymin, ymax;
  logic signed [11:0] cx, cy;
  logic               draining;
  logic signed [26:0] e01, e12, e20, area;
  logic               covered, adv, at_last, accept;

  assign e01     = edge_fn(r0x, r0y, r1x, r1y, cx, cy);
  assign e12     = edge_fn(r1x, r1y, r2x, r2y, cx, cy);
  assign e20     = edge_fn(r2x, r2y, r0x, r0y, cx, cy);
  assign area    = edge_fn(r0x, r0y, r1x, r1y, r2x, r2y);
  assign covered = inside3(e01, e12, e20);
  assign accept  = (state == IDLE) && start;
  assign adv     = !out_valid || out_ready;
  // Equality compare keeps the cursor safe at the +2047 / -2048 extremes.
  assign at_last = (cx == xmax) && (cy == ymax);

  // Vertex, bounding-box and cursor registers carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      r0x <= v0x;
      r0y <= v0y;
      r1x <= v1x;
      r1y <= v1y;
      r2x <= v2x;
      r2y <= v2y;
    end
    if (state == SETUP) begin
      xmin <= min3(r0x, r1x, r2x);
      xmax <= max3(r0x, r1x, r2x);
      ymin <= min3(r0y, r1y, r2y);
      ymax <= max3(r0y, r1y, r2y);
      cx   <= min3(r0x, r1x, r2x);
      cy   <= min3(r0y, r1y, r2y);
    end else if (state == SCAN && !draining && adv && !at_last) begin
      if (cx == xmax) begin
        cx <= xmin;
        cy <= cy + 12'sd1;
      end else begin
        cx <= cx + 12'sd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      done      <= 1'b0;
      pix_count <= '0;
      draining  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready)
        pix_count <= pix_count + 24'd1;
      case (state)
        IDLE: begin
          if (start) begin
            pix_count <= '0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          draining <= 1'b0;
          if (area == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (draining) begin
            // Last pixel is covered and parked in the output stage.
            if (adv) begin
              out_valid <= 1'b0;
              draining  <= 1'b0;
              state     <= DONE;
              done      <= 1'b1;
            end
          end else if (adv) begin
            out_x     <= cx;
            out_y     <= cy;
            out_valid <= covered;
            if (at_last) begin
              if (covered) begin
                draining <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
